// File: rtl/imm_enc.sv
// imm_enc: packs a 32-bit immediate into the I/S/B/J immediate fields of an
// RV32 instruction template and flags values that cannot be encoded.
// The path is two registered stages (S1 inputs, S2 encoded word and flags)
// with valid/ready backpressure and a synchronous flush.
// Optional build macro IMM_ENC_ERRCNT_EN adds the saturating err_cnt output.
module imm_enc #(
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       ins_in,
    input  logic [31:0]       imm_in,
    input  logic [2:0]        imm_sel,
    input  logic [TAG_W-1:0]  tag_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       ins_out,
    output logic [TAG_W-1:0]  tag_out,
    output logic              err_range,
    output logic              err_align,
    output logic              err_sel
`ifdef IMM_ENC_ERRCNT_EN
    ,
    output logic [CNT_W-1:0]  err_cnt
`endif
);

    localparam logic [2:0] SEL_I = 3'b001;
    localparam logic [2:0] SEL_S = 3'b010;
    localparam logic [2:0] SEL_B = 3'b011;
    localparam logic [2:0] SEL_J = 3'b100;

    // True when v[31:lsb] is a pure sign extension, i.e. v fits the field.
    function automatic logic fits_signed(input logic signed [31:0] v, input int unsigned lsb);
        logic signed [31:0] hi;
        hi = v >>> lsb;
        return (hi == '0) || (hi == '1);
    endfunction

    logic                     s1_v_q, s1_v_d;
    logic                     s2_v_q, s2_v_d;
    logic [31:0]              s1_ins_q;
    logic signed [31:0]       s1_imm_q;
    logic [2:0]               s1_sel_q;
    logic [TAG_W-1:0]         s1_tag_q;
    logic [31:0]              s2_ins_q, s2_ins_d;
    logic [TAG_W-1:0]         s2_tag_q;
    logic                     s2_rng_q, s2_rng_d;
    logic                     s2_aln_q, s2_aln_d;
    logic                     s2_sel_q, s2_sel_d;
    logic                     s2_adv;
    logic                     accept;

    // S2 may load when it is empty or its result is being consumed this cycle.
    assign s2_adv   = !s2_v_q || out_ready;
    assign in_ready = !flush && (!s1_v_q || s2_adv);
    assign accept   = in_valid && in_ready;

    // Next-state of the two stage valid bits; flush empties both stages.
    always_comb begin
        s1_v_d = s1_v_q;
        s2_v_d = s2_v_q;
        if (flush) begin
            s1_v_d = 1'b0;
            s2_v_d = 1'b0;
        end else begin
            if (s2_adv) s2_v_d = s1_v_q;
            if (!s1_v_q || s2_adv) s1_v_d = accept;
        end
    end

    // Pack the S1 immediate into the template and derive the error flags.
    always_comb begin
        s2_ins_d = s1_ins_q;
        s2_rng_d = 1'b0;
        s2_aln_d = 1'b0;
        s2_sel_d = 1'b0;
        case (s1_sel_q)
            SEL_I: begin
                s2_ins_d[31:20] = s1_imm_q[11:0];
                s2_rng_d        = !fits_signed(s1_imm_q, 11);
            end
            SEL_S: begin
                s2_ins_d[31:25] = s1_imm_q[11:5];
                s2_ins_d[11:7]  = s1_imm_q[4:0];
                s2_rng_d        = !fits_signed(s1_imm_q, 11);
            end
            SEL_B: begin
                s2_ins_d[31]    = s1_imm_q[12];
                s2_ins_d[30:25] = s1_imm_q[10:5];
                s2_ins_d[11:8]  = s1_imm_q[4:1];
                s2_ins_d[7]     = s1_imm_q[11];
                s2_rng_d        = !fits_signed(s1_imm_q, 12);
                s2_aln_d        = s1_imm_q[0];
            end
            SEL_J: begin
                s2_ins_d[31]    = s1_imm_q[20];
                s2_ins_d[30:21] = s1_imm_q[10:1];
                s2_ins_d[20]    = s1_imm_q[11];
                s2_ins_d[19:12] = s1_imm_q[19:12];
                s2_rng_d        = !fits_signed(s1_imm_q, 20);
                s2_aln_d        = s1_imm_q[0];
            end
            default: begin
                s2_sel_d = 1'b1;
            end
        endcase
    end

    // Stage valid bits; in-flight data is discarded by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v_q <= 1'b0;
            s2_v_q <= 1'b0;
        end else begin
            s1_v_q <= s1_v_d;
            s2_v_q <= s2_v_d;
        end
    end

    // S1 captures the raw transfer on every accepted handshake.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_ins_q <= ins_in;
            s1_imm_q <= imm_in;
            s1_sel_q <= imm_sel;
            s1_tag_q <= tag_in;
        end
    end

    // S2 holds the encoded word and flags; it is frozen while the output stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_ins_q <= '0;
            s2_tag_q <= '0;
            s2_rng_q <= 1'b0;
            s2_aln_q <= 1'b0;
            s2_sel_q <= 1'b0;
        end else if (s2_adv && s1_v_q) begin
            s2_ins_q <= s2_ins_d;
            s2_tag_q <= s1_tag_q;
            s2_rng_q <= s2_rng_d;
            s2_aln_q <= s2_aln_d;
            s2_sel_q <= s2_sel_d;
        end
    end

    assign out_valid = s2_v_q;
    assign ins_out   = s2_ins_q;
    assign tag_out   = s2_tag_q;
    assign err_range = s2_rng_q;
    assign err_align = s2_aln_q;
    assign err_sel   = s2_sel_q;

`ifdef IMM_ENC_ERRCNT_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + 1'b1;
    endfunction

    logic [CNT_W-1:0] err_cnt_q;

    // Count consumed results carrying any error flag; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if (s2_v_q && out_ready && (s2_rng_q || s2_aln_q || s2_sel_q)) begin
            err_cnt_q <= sat_inc(err_cnt_q);
        end
    end

    assign err_cnt = err_cnt_q;
`else
    // No error counter in this build; CNT_W only sizes an unused stub.
    logic [CNT_W-1:0] unused_cnt_w;
    assign unused_cnt_w = '0;
`endif

endmodule
